adder16_rr_arbiter: RTL and testbench
=====================================

# adder16_rr_arbiter

Round-robin scheduler that shares one 16-bit ripple-carry adder datapath (sum plus sign/zero/carry/parity/overflow flags, carry-in tied to 0) among `NREQ` requesters. Each requester has a valid/ready request channel. The block captures one operand pair at a time, runs it through the adder, and returns the sum and flags on a shared response channel tagged with the requester index. Only one operation is in flight at a time. The block sits between the requesting datapath units and the single shared adder instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: width of the requester index, equal to clog2(`NREQ`).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `req_valid` input `NREQ`: per-requester request valid.
- `req_ready` output `NREQ`: per-requester accept; at most one bit is high in any cycle.
- `req_x` input `NREQ`*16: operand x, packed; requester i uses bits [16i+15:16i].
- `req_y` input `NREQ`*16: operand y, packed in the same layout as `req_x`.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response consumer ready.
- `rsp_id` output `IDW`: index of the requester that owns the response.
- `rsp_z` output 16: sum, x+y mod 2^16.
- `rsp_flags` output 5: {sign, zero, carry, parity, overflow}, bit 4 down to bit 0.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE, grant selection:
  - Scan requesters starting at round-robin pointer `ptr` and increasing modulo `NREQ`.
  - The first index with `req_valid` high is the winner.
  - `req_ready[winner]` is driven high combinationally in the same cycle. All other ready bits stay low.
  - If no requester is valid, no ready bit is raised and the FSM stays in IDLE.
- IDLE, accept (`req_valid[w]` and `req_ready[w]` both high at an edge):
  - Register `x`, `y` and `w`.
  - Set `ptr` to (w+1) mod `NREQ`.
  - Go to EXEC.
- EXEC:
  - The adder evaluates the registered operands.
  - Register `z` and the flags into the response registers.
  - Go to RESP.
- RESP:
  - `rsp_valid` is high.
  - When `rsp_ready` is high at an edge, the response completes: drop `rsp_valid` and go to IDLE.
  - No request is accepted in the cycle the response completes.
- Flag definitions, with carry-in 0:
  - sign = z[15].
  - zero = (z == 0).
  - carry = bit 16 of x+y.
  - parity = 1 when z has an even number of 1s (XNOR reduction).
  - overflow = (x[15] & y[15] & ~z[15]) | (~x[15] & ~y[15] & z[15]).
- Response stability: `rsp_id`, `rsp_z` and `rsp_flags` stay stable while `rsp_valid` is high and until the next EXEC. They keep their last values in IDLE.
- Input changes:
  - Changes on `req_x` or `req_y` after acceptance have no effect on the operation in flight.
  - A requester that drops `req_valid` without being accepted is never granted for that request.
- Fairness: a continuously valid requester is granted within `NREQ` operations.
- Reset:
  - `rst_n` low at any time, including mid-operation, forces IDLE and sets `ptr`=0.
  - The in-flight operation is discarded and no response is produced for it.
  - Output values under reset: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_z`=0, `rsp_flags`=0. The zero flag is 0 under reset even though `rsp_z` is 0, because the flags are registered.

## Timing
- Request accepted at edge N: EXEC during cycle N..N+1, `rsp_valid` high after edge N+1 (one cycle after accept).
- With `rsp_ready` held high, the response completes at edge N+2 and IDLE is re-entered.
- The next accept is possible at edge N+3 at the earliest, so peak throughput is one operation per 3 cycles.
- Backpressure: `rsp_valid` holds for any number of cycles with `rsp_ready` low. `req_ready` stays all-zero throughout.
- `req_ready` has a combinational path from `req_valid` in IDLE. There is no combinational path from `rsp_ready` to any output.
- Reset release: the first grant is possible in the first cycle with `rst_n` high.

## Test plan
- Single add, requester 2: x=16'h7FFF, y=16'h0001, `rsp_ready`=1. Expected: accept at edge N, response at N+1 with `rsp_id`=2, `rsp_z`=16'h8000, flags sign=1, zero=0, carry=0, parity=0, overflow=1.
- Zero and carry: x=16'hFFFF, y=16'h0001. Expected: `rsp_z`=0, flags sign=0, zero=1, carry=1, parity=1, overflow=0. Also check x=16'h8000, y=16'h8000: z=0, carry=1, overflow=1.
- Round robin: all 4 requesters valid continuously from reset, `rsp_ready`=1. Expected grant order 0,1,2,3,0, each accept 3 cycles apart. Then with only requesters 1 and 3 valid and `ptr`=2, the next grant goes to 3.
- Backpressure: `rsp_ready` held 0 for 5 cycles in RESP. Expected: `rsp_valid` and `rsp_z` held stable and `req_ready`=0 throughout, despite all `req_valid`=1. One completion occurs when `rsp_ready` rises.
- Operand isolation: change `req_x[0]` on the cycle after accept. Expected: the response reflects the originally captured operands.
- Reset mid-operation: assert `rst_n`=0 during EXEC. Expected: all outputs zero immediately, no response ever issued for that request, and after release requester 0 is granted first.

Source files
------------

// File: rtl/adder16_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit ripple-carry adder.
// One operation in flight: IDLE grant -> EXEC add -> RESP hold.
module adder16_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*16-1:0] req_x,
  input  logic [NREQ*16-1:0] req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_z,
  output logic [4:0]        rsp_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] id_q;
  logic           found;
  logic           accept;
  logic [15:0]    x_q;
  logic [15:0]    y_q;
  logic [15:0]    z;
  logic [16:0]    c;
  logic [4:0]     flags;

  // Scan requesters from ptr upward (mod NREQ); first valid wins.
  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
  end

  assign accept = (state == IDLE) && found;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: one-hot grant in IDLE, response valid in RESP.
  always_comb begin
    req_ready = '0;
    rsp_valid = (state == RESP);
    if (accept && rst_n) req_ready[win] = 1'b1;
  end

  // Capture operands, owner and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      id_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (accept) begin
      x_q  <= req_x[int'(win)*16 +: 16];
      y_q  <= req_y[int'(win)*16 +: 16];
      id_q <= win;
      if (int'(win) == NREQ - 1) ptr <= '0;
      else                       ptr <= win + IDW'(1);
    end
  end

  // Ripple-carry adder with carry-in tied low.
  always_comb begin
    z    = '0;
    c    = '0;
    c[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      z[i]   = x_q[i] ^ y_q[i] ^ c[i];
      c[i+1] = (x_q[i] & y_q[i]) | (c[i] & (x_q[i] ^ y_q[i]));
    end
  end

  // Flags: {sign, zero, carry, parity(even), overflow}.
  always_comb begin
    flags = {
      z[15],
      ~|z,
      c[16],
      ~^z,
      (x_q[15] & y_q[15] & ~z[15]) | (~x_q[15] & ~y_q[15] & z[15])
    };
  end

  // Response registers load in EXEC and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id    <= '0;
      rsp_z     <= '0;
      rsp_flags <= '0;
    end else if (state == EXEC) begin
      rsp_id    <= id_q;
      rsp_z     <= z;
      rsp_flags <= flags;
    end
  end

endmodule

// File: tb/tb_adder16_rr_arbiter.sv
// Bench for adder16_rr_arbiter: directed plan plus random ops
// against an arithmetic reference of arbitration and the adder.
module tb_adder16_rr_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*16-1:0] req_x;
  logic [NREQ*16-1:0] req_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_z;
  logic [4:0]        rsp_flags;

  adder16_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x(req_x),
    .req_y(req_y),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_z(rsp_z),
    .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int mptr   = 0;
  logic [15:0] mx [NREQ];
  logic [15:0] my [NREQ];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference sum/flags from plain integer arithmetic.
  function automatic logic [20:0] ref_add(input logic [15:0] x,
                                          input logic [15:0] y);
    int s, sx, sy, ss, zi;
    logic [15:0] zz;
    logic [4:0] f;
    s  = int'(x) + int'(y);
    zi = s % 65536;
    zz = 16'(zi);
    sx = (int'(x) >= 32768) ? int'(x) - 65536 : int'(x);
    sy = (int'(y) >= 32768) ? int'(y) - 65536 : int'(y);
    ss = sx + sy;
    f[4] = (zi >= 32768);
    f[3] = (zi == 0);
    f[2] = (s >= 65536);
    f[1] = (($countones(zz) % 2) == 0);
    f[0] = (ss > 32767) || (ss < -32768);
    return {zz, f};
  endfunction

  task automatic drive(input logic [NREQ-1:0] mask, input bit fixed,
                       input logic [15:0] fx, input logic [15:0] fy);
    for (int i = 0; i < NREQ; i++) begin
      mx[i] = fixed ? fx : 16'($urandom);
      my[i] = fixed ? fy : 16'($urandom);
      req_x[16*i +: 16] = mx[i];
      req_y[16*i +: 16] = my[i];
    end
    req_valid = mask;
  endtask

  function automatic int ref_grant(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++)
      if (mask[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return -1;
  endfunction

  // One full transaction, entered and left at a falling edge.
  task automatic run_op(input logic [NREQ-1:0] mask, input bit fixed,
                        input logic [15:0] fx, input logic [15:0] fy,
                        input int bp, input bit perturb,
                        output int got_id, output int acc_cyc,
                        output logic [20:0] got);
    int w;
    logic [20:0] exp;
    got_id  = -1;
    acc_cyc = -1;
    got     = '0;
    drive(mask, fixed, fx, fy);
    rsp_ready = (bp == 0);
    w = ref_grant(mask);
    #1;
    check("grant", req_ready, (w < 0) ? 0 : (1 << w));
    if (w < 0) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_no_rsp", rsp_valid, 0);
      return;
    end
    exp = ref_add(mx[w], my[w]);
    @(posedge clk);
    mptr = (w + 1) % NREQ;
    @(negedge clk);
    acc_cyc = cyc;
    if (perturb) drive(mask, 1'b0, 16'h0, 16'h0);
    #1;
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, w);
    check("rsp_z", rsp_z, exp[20:5]);
    check("rsp_flags", rsp_flags, exp[4:0]);
    check("resp_ready", req_ready, 0);
    got_id = int'(rsp_id);
    got    = {rsp_z, rsp_flags};
    for (int b = 0; b < bp; b++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_hold", {rsp_id, rsp_z, rsp_flags}, {IDW'(w), exp});
      check("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("done_valid", rsp_valid, 0);
  endtask

  initial begin
    int id, ac, prev;
    logic [20:0] r;
    rst_n     = 1'b0;
    req_valid = '1;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_outs", {rsp_valid, rsp_id, rsp_z, rsp_flags}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;

    // Round robin with everyone valid.
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      run_op(4'b1111, 1'b0, 16'h0, 16'h0, 0, 1'b0, id, ac, r);
      check("rr_order", id, k % 4);
      if (prev >= 0) check("rr_spacing", ac - prev, 3);
      prev = ac;
    end
    run_op(4'b0010, 1'b0, 16'h0, 16'h0, 0, 1'b0, id, ac, r);
    check("rr_req1", id, 1);
    run_op(4'b1010, 1'b0, 16'h0, 16'h0, 0, 1'b0, id, ac, r);
    check("rr_skip_to3", id, 3);

    // Directed adder corners.
    run_op(4'b0100, 1'b1, 16'h7FFF, 16'h0001, 0, 1'b0, id, ac, r);
    check("ovf_id", id, 2);
    check("ovf_res", r, {16'h8000, 5'b10001});
    run_op(4'b0001, 1'b1, 16'hFFFF, 16'h0001, 0, 1'b0, id, ac, r);
    check("zero_carry", r, {16'h0000, 5'b01110});
    run_op(4'b0001, 1'b1, 16'h8000, 16'h8000, 0, 1'b0, id, ac, r);
    check("neg_ovf", r, {16'h0000, 5'b01111});

    // Backpressure and operand isolation.
    run_op(4'b1111, 1'b0, 16'h0, 16'h0, 5, 1'b0, id, ac, r);
    run_op(4'b0001, 1'b0, 16'h0, 16'h0, 0, 1'b1, id, ac, r);

    // Reset during EXEC.
    drive(4'b0100, 1'b0, 16'h0, 16'h0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", req_ready, 0);
    check("midrst_outs", {rsp_valid, rsp_id, rsp_z, rsp_flags}, 0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    mptr  = 0;
    run_op(4'b1111, 1'b0, 16'h0, 16'h0, 0, 1'b0, id, ac, r);
    check("post_rst_first", id, 0);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom_range(0, 15)), 1'b0, 16'h0, 16'h0,
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             id, ac, r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
